// File: rtl/memory_arbiter.sv
// Two-port memory arbiter: serialises port a / port b accesses onto one synchronous memory port.
// Define MEMORY_ARBITER_FIXED_PRIORITY_EN for fixed a-over-b priority; default is round-robin.
module memory_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  a_request_i,
    input  logic                  a_write_i,
    input  logic [ADDR_WIDTH-1:0] a_address_i,
    input  logic [DATA_WIDTH-1:0] a_write_data_i,
    output logic                  a_ready_o,
    output logic [DATA_WIDTH-1:0] a_read_data_o,
    input  logic                  b_request_i,
    input  logic                  b_write_i,
    input  logic [ADDR_WIDTH-1:0] b_address_i,
    input  logic [DATA_WIDTH-1:0] b_write_data_i,
    output logic                  b_ready_o,
    output logic [DATA_WIDTH-1:0] b_read_data_o,
    output logic                  grant_owner_o,
    output logic                  memory_write_enable_o,
    output logic [ADDR_WIDTH-1:0] memory_address_o,
    output logic [DATA_WIDTH-1:0] memory_write_data_o,
    input  logic [DATA_WIDTH-1:0] memory_read_data_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    win_b;

`ifndef MEMORY_ARBITER_FIXED_PRIORITY_EN
    // Port served by the previous grant; starts at b so a wins the first tie.
    logic                    last_b_q, last_b_d;
`endif

`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
    assign win_b = b_request_i && !a_request_i;
`else
    assign win_b = b_request_i && (!a_request_i || !last_b_q);
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifndef MEMORY_ARBITER_FIXED_PRIORITY_EN
            last_b_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifndef MEMORY_ARBITER_FIXED_PRIORITY_EN
            last_b_q    <= last_b_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifndef MEMORY_ARBITER_FIXED_PRIORITY_EN
        last_b_d    = last_b_q;
`endif
        case (state_q)
            IDLE: begin
                mem_we_d = 1'b0;
                if (a_request_i || b_request_i) begin
                    state_d     = ISSUE;
                    owner_d     = win_b;
                    mem_we_d    = win_b ? b_write_i      : a_write_i;
                    mem_addr_d  = win_b ? b_address_i    : a_address_i;
                    mem_wdata_d = win_b ? b_write_data_i : a_write_data_i;
`ifndef MEMORY_ARBITER_FIXED_PRIORITY_EN
                    last_b_d    = win_b;
`endif
                end
            end
            ISSUE: begin
                mem_we_d = 1'b0;
                state_d  = CAPTURE;
            end
            CAPTURE: begin
                mem_we_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                mem_we_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // Read data is a pass-through; it only matters while the matching ready is high.
    always_comb begin
        a_ready_o             = (state_q == CAPTURE) && !owner_q;
        b_ready_o             = (state_q == CAPTURE) &&  owner_q;
        a_read_data_o         = memory_read_data_i;
        b_read_data_o         = memory_read_data_i;
        grant_owner_o         = owner_q;
        memory_write_enable_o = mem_we_q;
        memory_address_o      = mem_addr_q;
        memory_write_data_o   = mem_wdata_q;
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter with a 1-cycle synchronous memory model.
// Expectations follow MEMORY_ARBITER_FIXED_PRIORITY_EN when the bench is built with it.
module tb_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_request, a_write, b_request, b_write;
    logic [15:0] a_address, a_write_data, b_address, b_write_data;
    logic        a_ready, b_ready, grant_owner, memory_write_enable;
    logic [15:0] a_read_data, b_read_data, memory_address, memory_write_data, memory_read_data;

    logic        pl_en;
    logic [15:0] pl_addr, pl_data;
    logic [15:0] mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clock_i               (clock),
        .reset_i               (reset),
        .a_request_i           (a_request),
        .a_write_i             (a_write),
        .a_address_i           (a_address),
        .a_write_data_i        (a_write_data),
        .a_ready_o             (a_ready),
        .a_read_data_o         (a_read_data),
        .b_request_i           (b_request),
        .b_write_i             (b_write),
        .b_address_i           (b_address),
        .b_write_data_i        (b_write_data),
        .b_ready_o             (b_ready),
        .b_read_data_o         (b_read_data),
        .grant_owner_o         (grant_owner),
        .memory_write_enable_o (memory_write_enable),
        .memory_address_o      (memory_address),
        .memory_write_data_o   (memory_write_data),
        .memory_read_data_i    (memory_read_data)
    );

    // Memory model: synchronous write, registered read (read-before-write).
    always @(posedge clock) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (memory_write_enable)
            mem[memory_address] <= memory_write_data;
        memory_read_data <= mem[memory_address];
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] addr, input logic [15:0] data);
        pl_en   = 1'b1;
        pl_addr = addr;
        pl_data = data;
        step();
        pl_en   = 1'b0;
    endtask

    initial begin : stimulus
        logic exp_owner;
        reset = 1'b1;
        a_request = 1'b0; a_write = 1'b0; a_address = '0; a_write_data = '0;
        b_request = 1'b0; b_write = 1'b0; b_address = '0; b_write_data = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        preload(16'h0010, 16'hBEEF);
        preload(16'h0001, 16'h1111);
        preload(16'h0002, 16'h2222);
        preload(16'h0200, 16'h0000);

        chk("rst_we",    memory_write_enable, 0);
        chk("rst_addr",  memory_address,      0);
        chk("rst_wdata", memory_write_data,   0);
        chk("rst_owner", grant_owner,         0);
        chk("rst_ardy",  a_ready,             0);
        chk("rst_brdy",  b_ready,             0);
        reset = 1'b0;
        step();

        // 1: port a read of 0x0010
        a_request = 1'b1; a_write = 1'b0; a_address = 16'h0010;
        step();
        chk("t1_addr",  memory_address,      16'h0010);
        chk("t1_we",    memory_write_enable, 0);
        chk("t1_ardy0", a_ready,             0);
        chk("t1_owner", grant_owner,         0);
        step();
        chk("t1_ardy",  a_ready,     1);
        chk("t1_brdy",  b_ready,     0);
        chk("t1_rdata", a_read_data, 16'hBEEF);
        a_request = 1'b0;
        step();
        chk("t1_ardy_end", a_ready, 0);

        // 2: port b write 0x0200 <= 0x1234, then port a reads it back
        b_request = 1'b1; b_write = 1'b1; b_address = 16'h0200; b_write_data = 16'h1234;
        step();
        chk("t2_we",    memory_write_enable, 1);
        chk("t2_addr",  memory_address,      16'h0200);
        chk("t2_wdata", memory_write_data,   16'h1234);
        chk("t2_owner", grant_owner,         1);
        chk("t2_brdy0", b_ready,             0);
        step();
        chk("t2_we_off", memory_write_enable, 0);
        chk("t2_brdy",   b_ready,             1);
        chk("t2_ardy",   a_ready,             0);
        b_request = 1'b0; b_write = 1'b0;
        step();
        a_request = 1'b1; a_address = 16'h0200;
        step();
        chk("t2r_we",    memory_write_enable, 0);
        chk("t2r_owner", grant_owner,         0);
        step();
        chk("t2r_ardy",  a_ready,     1);
        chk("t2r_rdata", a_read_data, 16'h1234);
        a_request = 1'b0;
        step();

        // 3: both ports request continuously from reset
        reset = 1'b1;
        a_request = 1'b1; a_address = 16'h0010;
        b_request = 1'b1; b_write = 1'b0; b_address = 16'h0200;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
            exp_owner = 1'b0;
`else
            exp_owner = i[0];
`endif
            step();
            chk("t3_owner", grant_owner, exp_owner);
            chk("t3_addr",  memory_address, exp_owner ? 16'h0200 : 16'h0010);
            chk("t3_rdy0",  {a_ready, b_ready}, 0);
            step();
            chk("t3_ardy", a_ready, !exp_owner);
            chk("t3_brdy", b_ready, exp_owner);
            if (exp_owner) chk("t3_brdata", b_read_data, 16'h1234);
            else           chk("t3_ardata", a_read_data, 16'hBEEF);
            step();
            chk("t3_idle_rdy", {a_ready, b_ready}, 0);
        end
        // 5: a drops; lone b is served with ready two cycles later
        a_request = 1'b0;
        step();
        chk("t5_owner", grant_owner, 1);
        step();
        chk("t5_brdy", b_ready, 1);
        chk("t5_ardy", a_ready, 0);
        b_request = 1'b0;
        step();

        // 4: reset during ISSUE of a write
        a_request = 1'b1; a_write = 1'b1; a_address = 16'h0300; a_write_data = 16'h5555;
        step();
        chk("t4_we_issue", memory_write_enable, 1);
        reset = 1'b1; a_request = 1'b0; a_write = 1'b0;
        step();
        reset = 1'b0;
        chk("t4_we",    memory_write_enable, 0);
        chk("t4_addr",  memory_address,      0);
        chk("t4_wdata", memory_write_data,   0);
        chk("t4_owner", grant_owner,         0);
        chk("t4_rdy",   {a_ready, b_ready},  0);
        step();
        chk("t4_rdy_after", {a_ready, b_ready}, 0);
        a_request = 1'b1; a_address = 16'h0010;
        step();
        chk("t4_resume_addr", memory_address, 16'h0010);
        step();
        chk("t4_resume_ardy",  a_ready,     1);
        chk("t4_resume_rdata", a_read_data, 16'hBEEF);
        a_request = 1'b0;
        step();

        // 6: address change after grant does not affect the access
        a_request = 1'b1; a_address = 16'h0001;
        step();
        chk("t6_addr", memory_address, 16'h0001);
        a_address = 16'h0002;
        step();
        chk("t6_ardy",  a_ready,        1);
        chk("t6_rdata", a_read_data,    16'h1111);
        chk("t6_addr2", memory_address, 16'h0001);
        a_request = 1'b0;
        step();
        chk("t6_idle_rdy", a_ready, 0);
        step();
        chk("t6_no_extra",  a_ready,        0);
        chk("t6_addr_hold", memory_address, 16'h0001);
        chk("t6_we",        memory_write_enable, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
